carregador_instrucoes: RTL and testbench
========================================

CARREGADOR_INSTRUCOES -- requirements
Module: carregador_instrucoes

Interface
REQ-001 Parameter: INSTR_VAZIA, default 8'h00, instruction word returned for any address not loaded.
REQ-002 Port: CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: RST_N  input  1  reset, synchronous and active-low.
REQ-004 Port: dado_carga  input  8  program byte offered by the host loader.
REQ-005 Port: valido_carga  input  1  dado_carga is valid this cycle.
REQ-006 Port: fim_carga  input  1  current valid byte is the last program byte.
REQ-007 Port: pronto_carga  output  1  block accepts a byte this cycle.
REQ-008 Port: saidaPC  input  8  program counter from the processor core.
REQ-009 Port: saida_instrucao  output  8  instruction word to the processor core.
REQ-010 Port: executando  output  1  core clock-enable; high only in state EXECUTA.
REQ-011 Port: parado  output  1  core has reached the halt address.
REQ-012 Port: contagem  output  9  number of bytes loaded (0..256).
REQ-013 Port: estado  output  2  current FSM state encoding.

Function
REQ-014 FSM states SHALL be CARGA=2'b00, EXECUTA=2'b01, PARADO=2'b10; 2'b11 is illegal and SHALL fall to CARGA on the next edge.
REQ-015 In CARGA, pronto_carga SHALL be 1 while contagem<256, and 0 in every other state.
REQ-016 A transfer occurs on an edge where valido_carga&&pronto_carga; dado_carga SHALL be written to memory address contagem[7:0], and contagem SHALL increment by 1.
REQ-017 fim_carga SHALL be sampled only on a transfer edge; when asserted, the state SHALL be EXECUTA on the following cycle.
REQ-018 On the transfer that makes contagem=256, the state SHALL go to EXECUTA whatever the value of fim_carga.
REQ-019 fim_carga without valido_carga SHALL be ignored, so a program holds at least one byte.
REQ-020 In EXECUTA, saida_instrucao SHALL combinationally equal mem[saidaPC] when saidaPC<contagem, else INSTR_VAZIA, with zero-cycle latency (the core is single-cycle).
REQ-021 In CARGA and PARADO, saida_instrucao SHALL equal INSTR_VAZIA.
REQ-022 In EXECUTA, sampling saidaPC==8'hFF on an edge SHALL move the state to PARADO on the next cycle.
REQ-023 PARADO SHALL be sticky until reset; parado=1 only in PARADO, and executando=0 there.
REQ-024 Memory SHALL not be written outside CARGA; valido_carga in EXECUTA or PARADO has no effect.
REQ-025 contagem SHALL hold its value in EXECUTA and PARADO.

Reset
REQ-026 With RST_N=0 at an edge: estado=CARGA, contagem=0, pronto_carga=1, executando=0, parado=0, saida_instrucao=INSTR_VAZIA.
REQ-027 Memory contents SHALL not be reset; stale bytes are masked by contagem=0 (REQ-020).
REQ-028 Reset asserted mid-load or mid-execution SHALL take priority over any simultaneous transfer or halt detection.

Structure
REQ-029 The state encodings, PC_PARADA=8'hFF and PROFUNDIDADE=256 SHALL live in a shared package used by the core top level.
REQ-030 Storage SHALL be one sub-module memoria_256x8 with a synchronous write port and an asynchronous read port; the FSM and counter stay in carregador_instrucoes.

Verification
REQ-031 The bench SHALL reset, then send bytes 8'h11, 8'h22, 8'h33 with fim_carga on 8'h33. Required: contagem=3 and estado=EXECUTA one cycle after the last transfer.
REQ-032 In EXECUTA after REQ-031, the bench SHALL drive saidaPC=1, then 3. Required: saida_instrucao=8'h22 in the same cycle, then INSTR_VAZIA.
REQ-033 The bench SHALL send 256 bytes with fim_carga=0. Required: estado=EXECUTA, contagem=256, pronto_carga=0; a 257th valid byte is not written.
REQ-034 In EXECUTA, the bench SHALL drive saidaPC=8'hFF for one cycle. Required: parado=1, executando=0 from the next cycle, held while saidaPC returns to 0.
REQ-035 The bench SHALL pull RST_N=0 after 2 of 5 bytes and then reload the single byte 8'hA5 with fim_carga. Required: contagem=1; saidaPC=1 returns INSTR_VAZIA, not the stale byte.
REQ-036 The bench SHALL drive valido_carga=0 with fim_carga=1 in CARGA. Required: no state change and contagem unchanged.

Source files
------------

// File: rtl/carregador_instrucoes_pkg.sv
// Shared definitions for the instruction loader: state encodings, halt address and memory depth.
package carregador_instrucoes_pkg;

    typedef enum logic [1:0] {
        StCarga   = 2'b00,
        StExecuta = 2'b01,
        StParado  = 2'b10,
        StIlegal  = 2'b11
    } estado_t;

    localparam logic [7:0]  PC_PARADA    = 8'hFF;
    localparam int unsigned PROFUNDIDADE = 256;

endpackage

// File: rtl/memoria_256x8.sv
// 256x8 program store: synchronous write, asynchronous read, contents never reset.
module memoria_256x8 (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] waddr,
    input  logic [7:0] wdata,
    input  logic [7:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem [256];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/carregador_instrucoes.sv
// Loads a program byte stream from the host, then serves it to a single-cycle core until the
// core reaches the halt address.
module carregador_instrucoes
    import carregador_instrucoes_pkg::*;
#(
    parameter logic [7:0] INSTR_VAZIA = 8'h00
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] dado_carga,
    input  logic       valido_carga,
    input  logic       fim_carga,
    output logic       pronto_carga,
    input  logic [7:0] saidaPC,
    output logic [7:0] saida_instrucao,
    output logic       executando,
    output logic       parado,
    output logic [8:0] contagem,
    output logic [1:0] estado
);

    estado_t    estado_q, estado_d;
    logic [8:0] contagem_q, contagem_d;
    logic       transferencia;
    logic       ultimo_byte;
    logic [7:0] dado_lido;

    always_comb begin
        pronto_carga  = (estado_q == StCarga) && (contagem_q < 9'(PROFUNDIDADE));
        transferencia = valido_carga && pronto_carga;
        ultimo_byte   = (contagem_q == 9'(PROFUNDIDADE - 1));
        contagem_d    = transferencia ? contagem_q + 9'd1 : contagem_q;
        estado_d      = estado_q;
        case (estado_q)
            StCarga: begin
                if (transferencia && (fim_carga || ultimo_byte)) begin
                    estado_d = StExecuta;
                end
            end
            StExecuta: begin
                if (saidaPC == PC_PARADA) begin
                    estado_d = StParado;
                end
            end
            StParado: estado_d = StParado;
            default:  estado_d = StCarga;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            estado_q   <= StCarga;
            contagem_q <= 9'd0;
        end else begin
            estado_q   <= estado_d;
            contagem_q <= contagem_d;
        end
    end

    // Write is gated by reset so a transfer coinciding with reset leaves memory untouched.
    memoria_256x8 u_memoria (
        .clk   (CLK),
        .we    (transferencia && RST_N),
        .waddr (contagem_q[7:0]),
        .wdata (dado_carga),
        .raddr (saidaPC),
        .rdata (dado_lido)
    );

    // Addresses at or beyond contagem hold stale bytes from earlier loads; mask them.
    always_comb begin
        saida_instrucao = INSTR_VAZIA;
        if ((estado_q == StExecuta) && ({1'b0, saidaPC} < contagem_q)) begin
            saida_instrucao = dado_lido;
        end
    end

    assign executando = (estado_q == StExecuta);
    assign parado     = (estado_q == StParado);
    assign contagem   = contagem_q;
    assign estado     = estado_q;

endmodule

// File: tb/tb_carregador_instrucoes.sv
// Directed bench for carregador_instrucoes with an expectation queue checked by immediate asserts.
module tb_carregador_instrucoes;

    localparam logic [7:0] VAZIA = 8'hEE;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [7:0] dado_carga;
    logic       valido_carga;
    logic       fim_carga;
    logic       pronto_carga;
    logic [7:0] saidaPC;
    logic [7:0] saida_instrucao;
    logic       executando;
    logic       parado;
    logic [8:0] contagem;
    logic [1:0] estado;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [15:0] esperado;
    } item_t;

    item_t fila[$];

    carregador_instrucoes #(
        .INSTR_VAZIA (VAZIA)
    ) dut (
        .CLK             (CLK),
        .RST_N           (RST_N),
        .dado_carga      (dado_carga),
        .valido_carga    (valido_carga),
        .fim_carga       (fim_carga),
        .pronto_carga    (pronto_carga),
        .saidaPC         (saidaPC),
        .saida_instrucao (saida_instrucao),
        .executando      (executando),
        .parado          (parado),
        .contagem        (contagem),
        .estado          (estado)
    );

    always #5 CLK = ~CLK;

    task automatic espera(input string tag, input logic [15:0] valor);
        item_t it;
        it.tag      = tag;
        it.esperado = valor;
        fila.push_back(it);
    endtask

    task automatic confere(input logic [15:0] obs);
        item_t it;
        checks++;
        if (fila.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
        end else begin
            it = fila.pop_front();
            assert (obs === it.esperado) else begin
                failures++;
                $error("FAIL %s: observed %0h required %0h", it.tag, obs, it.esperado);
            end
        end
    endtask

    task automatic ciclo();
        @(posedge CLK);
        #1;
    endtask

    task automatic envia(input logic [7:0] d, input logic fim);
        dado_carga   = d;
        valido_carga = 1'b1;
        fim_carga    = fim;
        ciclo();
        valido_carga = 1'b0;
        fim_carga    = 1'b0;
    endtask

    task automatic confere_estado(input string tag, input logic [1:0] e, input logic [8:0] c);
        espera({tag, "_estado"}, 16'(e));
        confere(16'(estado));
        espera({tag, "_contagem"}, 16'(c));
        confere(16'(contagem));
    endtask

    task automatic le(input string tag, input logic [7:0] pc, input logic [7:0] instr);
        saidaPC = pc;
        #1;
        espera(tag, 16'(instr));
        confere(16'(saida_instrucao));
    endtask

    initial begin
        RST_N        = 1'b0;
        dado_carga   = 8'h00;
        valido_carga = 1'b0;
        fim_carga    = 1'b0;
        saidaPC      = 8'h00;
        ciclo();
        ciclo();

        // Reset values
        confere_estado("reset", 2'b00, 9'd0);
        espera("reset_pronto", 16'd1);      confere(16'(pronto_carga));
        espera("reset_exec", 16'd0);        confere(16'(executando));
        espera("reset_parado", 16'd0);      confere(16'(parado));
        espera("reset_instr", 16'(VAZIA));  confere(16'(saida_instrucao));
        RST_N = 1'b1;

        // fim_carga without valido_carga is ignored
        fim_carga = 1'b1;
        ciclo();
        fim_carga = 1'b0;
        confere_estado("fim_sem_valido", 2'b00, 9'd0);

        // Three-byte program
        envia(8'h11, 1'b0);
        envia(8'h22, 1'b0);
        espera("carga_parcial_instr", 16'(VAZIA)); confere(16'(saida_instrucao));
        envia(8'h33, 1'b1);
        confere_estado("carga3", 2'b01, 9'd3);
        espera("carga3_exec", 16'd1);   confere(16'(executando));
        espera("carga3_pronto", 16'd0); confere(16'(pronto_carga));
        le("pc1", 8'd1, 8'h22);
        le("pc3", 8'd3, VAZIA);
        le("pc0", 8'd0, 8'h11);
        le("pc2", 8'd2, 8'h33);

        // Bytes offered in EXECUTA have no effect
        saidaPC = 8'd0;
        envia(8'h99, 1'b1);
        confere_estado("valido_em_exec", 2'b01, 9'd3);
        le("pc0_pos_exec", 8'd0, 8'h11);

        // Halt, then stays halted
        saidaPC = 8'hFF;
        ciclo();
        saidaPC = 8'h00;
        espera("halt_parado", 16'd1);  confere(16'(parado));
        espera("halt_exec", 16'd0);    confere(16'(executando));
        confere_estado("halt", 2'b10, 9'd3);
        ciclo();
        ciclo();
        espera("halt_retido", 16'd1);  confere(16'(parado));
        espera("halt_instr", 16'(VAZIA)); confere(16'(saida_instrucao));
        confere_estado("halt_retido", 2'b10, 9'd3);

        // Full 256-byte load with fim_carga low
        RST_N = 1'b0;
        ciclo();
        RST_N = 1'b1;
        for (int i = 0; i < 255; i++) begin
            envia(8'(i) ^ 8'h5A, 1'b0);
        end
        confere_estado("carga255", 2'b00, 9'd255);
        espera("carga255_pronto", 16'd1); confere(16'(pronto_carga));
        envia(8'hFF ^ 8'h5A, 1'b0);
        confere_estado("carga256", 2'b01, 9'd256);
        espera("carga256_pronto", 16'd0); confere(16'(pronto_carga));
        envia(8'hC3, 1'b0);
        confere_estado("byte257", 2'b01, 9'd256);
        le("full_pc0", 8'd0, 8'h5A);
        le("full_pc128", 8'd128, 8'h80 ^ 8'h5A);
        le("full_pcff", 8'hFF, 8'hFF ^ 8'h5A);
        ciclo();
        saidaPC = 8'h00;
        confere_estado("full_halt", 2'b10, 9'd256);

        // Reset mid-load takes priority over a simultaneous transfer
        RST_N = 1'b0;
        ciclo();
        RST_N = 1'b1;
        envia(8'h01, 1'b0);
        envia(8'h02, 1'b0);
        dado_carga   = 8'h03;
        valido_carga = 1'b1;
        fim_carga    = 1'b1;
        RST_N        = 1'b0;
        ciclo();
        RST_N        = 1'b1;
        valido_carga = 1'b0;
        fim_carga    = 1'b0;
        confere_estado("reset_meio", 2'b00, 9'd0);
        envia(8'hA5, 1'b1);
        confere_estado("recarga", 2'b01, 9'd1);
        le("recarga_pc0", 8'd0, 8'hA5);
        le("recarga_pc1_mascarado", 8'd1, VAZIA);

        // Reset beats halt detection
        saidaPC = 8'hFF;
        RST_N   = 1'b0;
        ciclo();
        RST_N   = 1'b1;
        saidaPC = 8'h00;
        confere_estado("reset_vs_halt", 2'b00, 9'd0);
        espera("reset_vs_halt_parado", 16'd0); confere(16'(parado));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
